// File: rtl/melody_seq.sv
// Programmable melody sequencer on the PWM sample clock: plays (pitch, duration) notes from a
// writable memory at a programmable tempo. Define MELODY_GAP_EN for detached articulation.
module melody_seq #(
    parameter int PITCH_W   = 5,
    parameter int DUR_W     = 13,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int TDIV_W    = 16,
    parameter int GAP_TICKS = 1
) (
    input  logic               fs_clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PITCH_W-1:0] wr_pitch,
    input  logic [DUR_W-1:0]   wr_dur,
    input  logic [ADDR_W:0]    len,
    input  logic [TDIV_W-1:0]  tempo_div,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic [PITCH_W-1:0] pitch_o,
    output logic               note_valid,
    output logic [ADDR_W-1:0]  note_idx,
    output logic               note_start,
    output logic               busy,
    output logic               done
);
`ifdef MELODY_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [DUR_W-1:0] GAP_L   = DUR_W'(GAP_TICKS);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t             state_q, state_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               ns_q, ns_d;
    logic               done_q, done_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [DUR_W-1:0]   cur_dur_q, cur_dur_d;
    logic [TDIV_W-1:0]  tick_q, tick_d;
    logic [DUR_W-1:0]   dcnt_q, dcnt_d;

    logic [PITCH_W-1:0] mem_pitch [DEPTH];
    logic [DUR_W-1:0]   mem_dur   [DEPTH];

    logic [DUR_W-1:0]   dur_eff;
    logic [ADDR_W:0]    len_clamp;
    logic               last_note;

    // Reads happen on the LOAD edge, so a write on that same edge is seen only afterwards.
    always_ff @(posedge fs_clk) begin
        if (wr_en) begin
            mem_pitch[wr_addr] <= wr_pitch;
            mem_dur[wr_addr]   <= wr_dur;
        end
    end

    function automatic logic gap_at(input logic [DUR_W-1:0] cnt, input logic [DUR_W-1:0] deff);
        return GAP_EN && (deff > GAP_L) && (cnt >= deff - GAP_L);
    endfunction

    always_comb begin
        dur_eff   = (cur_dur_q == '0) ? DUR_W'(1) : cur_dur_q;
        len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
        last_note = ({1'b0, idx_q} == len_q - (ADDR_W+1)'(1));

        state_d   = state_q;
        pitch_d   = pitch_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        ns_d      = 1'b0;
        done_d    = 1'b0;
        len_d     = len_q;
        cur_dur_d = cur_dur_q;
        tick_d    = tick_q;
        dcnt_d    = dcnt_q;

        if (stop) begin
            state_d = IDLE;
            pitch_d = '0;
            valid_d = 1'b0;
            idx_d   = '0;
            tick_d  = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && len_clamp != '0) begin
                        state_d = LOAD;
                        idx_d   = '0;
                        len_d   = len_clamp;
                    end
                end
                LOAD: begin
                    state_d   = PLAY;
                    pitch_d   = mem_pitch[idx_q];
                    cur_dur_d = mem_dur[idx_q];
                    valid_d   = (mem_pitch[idx_q] != '0);
                    ns_d      = 1'b1;
                    tick_d    = '0;
                    dcnt_d    = '0;
                end
                PLAY: begin
                    // A shrunken tempo_div resets the tick phase without counting a tick.
                    if (tick_q > tempo_div) begin
                        tick_d = '0;
                    end else if (tick_q == tempo_div) begin
                        tick_d = '0;
                        if (dcnt_q == dur_eff - DUR_W'(1)) begin
                            if (!last_note) begin
                                idx_d   = idx_q + 1'b1;
                                state_d = LOAD;
                            end else if (loop_en) begin
                                idx_d   = '0;
                                state_d = LOAD;
                            end else begin
                                state_d = IDLE;
                                pitch_d = '0;
                                valid_d = 1'b0;
                                idx_d   = '0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            dcnt_d  = dcnt_q + DUR_W'(1);
                            valid_d = (pitch_q != '0) && !gap_at(dcnt_q + DUR_W'(1), dur_eff);
                        end
                    end else begin
                        tick_d = tick_q + TDIV_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge fs_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pitch_q   <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            ns_q      <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            cur_dur_q <= '0;
            tick_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pitch_q   <= pitch_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            ns_q      <= ns_d;
            done_q    <= done_d;
            len_q     <= len_d;
            cur_dur_q <= cur_dur_d;
            tick_q    <= tick_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign pitch_o    = pitch_q;
    assign note_valid = valid_q;
    assign note_idx   = idx_q;
    assign note_start = ns_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: per-cycle expected traces are built from the note list with plain
// arithmetic (LOAD cycle, then dur*(tempo_div+1) play cycles per note) and compared every cycle.
module tb_melody_seq;
    localparam int PW = 5;
    localparam int DW = 13;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int TW = 16;
`ifdef MELODY_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic          fs_clk;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_pitch;
    logic [DW-1:0] wr_dur;
    logic [AW:0]   len;
    logic [TW-1:0] tempo_div;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic [PW-1:0] pitch_o;
    logic          note_valid;
    logic [AW-1:0] note_idx;
    logic          note_start;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] m_pitch [DEPTH];
    logic [DW-1:0] m_dur   [DEPTH];
    logic [13:0]   exp_q[$];

    melody_seq dut (
        .fs_clk(fs_clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pitch(wr_pitch), .wr_dur(wr_dur), .len(len), .tempo_div(tempo_div),
        .loop_en(loop_en), .start(start), .stop(stop), .pitch_o(pitch_o),
        .note_valid(note_valid), .note_idx(note_idx), .note_start(note_start),
        .busy(busy), .done(done)
    );

    // clock / reset
    initial fs_clk = 1'b0;
    always #5 fs_clk = ~fs_clk;

    function automatic logic [13:0] pack(input logic [PW-1:0] p, input logic v,
                                         input logic [AW-1:0] i, input logic ns,
                                         input logic b, input logic d);
        return {p, v, i, ns, b, d};
    endfunction

    function automatic logic [13:0] observe();
        return pack(pitch_o, note_valid, note_idx, note_start, busy, done);
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_note(input int a, input int p, input int d);
        @(negedge fs_clk);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_pitch = PW'(p);
        wr_dur = DW'(d);
        @(negedge fs_clk);
        wr_en = 1'b0;
        m_pitch[a] = PW'(p);
        m_dur[a] = DW'(d);
    endtask

    // reference model: expected outputs for cycles 1.. after the start cycle
    task automatic build_trace(input int ln, input int tdiv, input int passes, output int pass_len);
        int n;
        int deff;
        logic [PW-1:0] prev_p;
        logic prev_v;
        logic v;
        n = (ln > DEPTH) ? DEPTH : ln;
        prev_p = '0;
        prev_v = 1'b0;
        pass_len = 0;
        exp_q.delete();
        for (int pass = 0; pass < passes; pass++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(pack(prev_p, prev_v, AW'(i), 1'b0, 1'b1, 1'b0));
                deff = (m_dur[i] == 0) ? 1 : int'(m_dur[i]);
                for (int j = 0; j < deff * (tdiv + 1); j++) begin
                    v = (m_pitch[i] != 0) && !(deff > GAP && (j / (tdiv + 1)) >= deff - GAP);
                    exp_q.push_back(pack(m_pitch[i], v, AW'(i), j == 0, 1'b1, 1'b0));
                    prev_p = m_pitch[i];
                    prev_v = v;
                end
                if (pass == 0) pass_len += 1 + deff * (tdiv + 1);
            end
        end
        exp_q.push_back(pack('0, 1'b0, '0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(pack('0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    endtask

    // driver + scoreboard: start a sequence and compare every cycle until the trace drains
    task automatic run_seq(input string tag, input int ln, input int tdiv, input int passes,
                           input int wr_cyc, input int wa, input int wp, input int wd);
        int pass_len;
        int last_pass;
        int cyc;
        logic [13:0] e;
        build_trace(ln, tdiv, passes, pass_len);
        last_pass = 1 + (passes - 1) * pass_len;
        @(negedge fs_clk);
        len = (AW+1)'(ln);
        tempo_div = TW'(tdiv);
        loop_en = (passes > 1);
        start = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge fs_clk);
            cyc++;
            start = 1'b0;
            wr_en = 1'b0;
            if (cyc == wr_cyc) begin
                wr_en = 1'b1;
                wr_addr = AW'(wa);
                wr_pitch = PW'(wp);
                wr_dur = DW'(wd);
            end
            if (passes > 1 && cyc == last_pass + 1) loop_en = 1'b0;
            e = exp_q.pop_front();
            chk($sformatf("%s_c%0d", tag, cyc), observe(), e);
        end
        wr_en = 1'b0;
        if (wr_cyc > 0) begin
            m_pitch[wa] = PW'(wp);
            m_dur[wa] = DW'(wd);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
        len = '0; tempo_div = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge fs_clk);
        chk("reset", observe(), 14'h0);
        reset = 1'b0;

        write_note(0, 18, 2); write_note(1, 0, 1); write_note(2, 13, 3);
        run_seq("three", 3, 0, 1, 0, 0, 0, 0);

        write_note(0, 20, 4);
        run_seq("tempo", 1, 3, 1, 0, 0, 0, 0);

        write_note(0, 5, 1); write_note(1, 6, 2);
        run_seq("loop", 2, 0, 3, 0, 0, 0, 0);

        write_note(0, 9, 0);
        run_seq("dur0", 1, 1, 1, 0, 0, 0, 0);

        write_note(0, 15, 3);
        run_seq("gap3", 1, 0, 1, 0, 0, 0, 0);
        write_note(0, 15, 1);
        run_seq("gap1", 1, 0, 1, 0, 0, 0, 0);

        // note 1 is loaded in cycle 3; a write to it then must not be heard
        write_note(0, 7, 1); write_note(1, 9, 1);
        run_seq("wrload", 2, 0, 1, 3, 1, 22, 1);
        run_seq("wrafter", 2, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++) write_note(i, $urandom_range(1, 31), $urandom_range(1, 2));
        run_seq("full", DEPTH, 0, 1, 0, 0, 0, 0);
        run_seq("clamp", 63, 0, 1, 0, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) write_note(i, $urandom_range(0, 31), $urandom_range(0, 4));
            run_seq($sformatf("rnd%0d", r), n, $urandom_range(0, 2), $urandom_range(1, 2), 0, 0, 0, 0);
        end

        // stop during PLAY
        write_note(0, 11, 50);
        @(negedge fs_clk);
        len = 1; tempo_div = 0; loop_en = 1'b0; start = 1'b1;
        @(negedge fs_clk); start = 1'b0;
        repeat (3) @(negedge fs_clk);
        chk("pre_stop", observe(), pack(5'd11, 1'b1, '0, 1'b0, 1'b1, 1'b0));
        stop = 1'b1;
        @(negedge fs_clk); stop = 1'b0;
        chk("stop_c1", observe(), 14'h0);
        @(negedge fs_clk);
        chk("stop_c2", observe(), 14'h0);

        // start and stop together from IDLE
        len = 2; start = 1'b1; stop = 1'b1;
        @(negedge fs_clk); start = 1'b0; stop = 1'b0;
        chk("startstop_c1", observe(), 14'h0);
        @(negedge fs_clk);
        chk("startstop_c2", observe(), 14'h0);

        // len = 0 start is ignored
        len = 0; start = 1'b1;
        @(negedge fs_clk); start = 1'b0;
        chk("len0_c1", observe(), 14'h0);
        @(negedge fs_clk);
        chk("len0_c2", observe(), 14'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
